// File: rtl/mipi_rx_raw_unpacker.sv
// Reassembles packed MIPI CSI-2 RAW8/10/12/14 payload bytes into groups of four
// 16-bit pixel slots, one group per cycle at most.
module mipi_rx_raw_unpacker #(
  parameter int LANES     = 4,
  parameter bit ALIGN_LSB = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 data_valid_i,
  input  logic [8*LANES-1:0]   data_i,
  input  logic [2:0]           packet_type_i,
  output logic                 output_valid_o,
  output logic [63:0]          output_o,
  output logic [15:0]          pixel_count_o,
  output logic                 residual_err_o,
  output logic                 unsupported_o
);

  localparam logic [2:0] TYPE_RAW8  = 3'd2;
  localparam logic [2:0] TYPE_RAW10 = 3'd3;
  localparam logic [2:0] TYPE_RAW12 = 3'd4;
  localparam logic [2:0] TYPE_RAW14 = 3'd5;

  logic [127:0] buf_reg, buf_next, buf_shift, data_ext;
  logic [4:0]   fill_reg, fill_next, fill_shift, need;
  logic [2:0]   type_reg, cur_type;
  logic         prev_valid_reg, armed_reg;
  logic         valid_reg, residual_reg, unsup_reg;
  logic [63:0]  out_reg, pixels;
  logic [15:0]  count_reg;
  logic         eff_valid, first_beat, flush, supported, emit;
  logic [3:0]   lsb_shift;
  logic [7:0]   b [7];
  logic [15:0]  px [4];

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bytes
      assign b[gi] = buf_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    // Bytes are ignored after reset until the input has been seen idle once.
    eff_valid  = data_valid_i & armed_reg;
    first_beat = eff_valid & ~prev_valid_reg;
    flush      = ~eff_valid & prev_valid_reg;
    cur_type   = first_beat ? packet_type_i : type_reg;
    supported  = 1'b1;
    need       = 5'd4;
    case (cur_type)
      TYPE_RAW8:  need = 5'd4;
      TYPE_RAW10: need = 5'd5;
      TYPE_RAW12: need = 5'd6;
      TYPE_RAW14: need = 5'd7;
      default:    supported = 1'b0;
    endcase
    emit       = (eff_valid | flush) & supported & (fill_reg >= need);
    fill_shift = emit ? fill_reg - need : fill_reg;
    buf_shift  = emit ? (buf_reg >> {need, 3'b000}) : buf_reg;
    data_ext   = '0;
    data_ext[8*LANES-1:0] = data_i;
    fill_next  = fill_reg;
    buf_next   = buf_reg;
    if (flush || (eff_valid && !supported)) begin
      fill_next = '0;
      buf_next  = '0;
    end else if (eff_valid) begin
      fill_next = fill_shift + 5'(LANES);
      buf_next  = buf_shift | (data_ext << {fill_shift, 3'b000});
    end
  end

  // Pixels are first built MSB-aligned, then optionally shifted down.
  always_comb begin
    lsb_shift = 4'd8;
    for (int k = 0; k < 4; k++) px[k] = {b[k], 8'h00};
    case (cur_type)
      TYPE_RAW10: begin
        lsb_shift = 4'd6;
        for (int k = 0; k < 4; k++) px[k] = {b[k], b[4][2*k +: 2], 6'b0};
      end
      TYPE_RAW12: begin
        lsb_shift = 4'd4;
        px[0] = {b[0], b[2][3:0], 4'b0};
        px[1] = {b[1], b[2][7:4], 4'b0};
        px[2] = {b[3], b[5][3:0], 4'b0};
        px[3] = {b[4], b[5][7:4], 4'b0};
      end
      TYPE_RAW14: begin
        lsb_shift = 4'd2;
        px[0] = {b[0], b[4][5:0], 2'b0};
        px[1] = {b[1], b[5][3:0], b[4][7:6], 2'b0};
        px[2] = {b[2], b[6][1:0], b[5][7:4], 2'b0};
        px[3] = {b[3], b[6][7:2], 2'b0};
      end
      default: ;
    endcase
    if (ALIGN_LSB) begin
      for (int k = 0; k < 4; k++) px[k] = px[k] >> lsb_shift;
    end
    pixels = {px[0], px[1], px[2], px[3]};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_reg        <= '0;
      fill_reg       <= '0;
      type_reg       <= TYPE_RAW8;
      prev_valid_reg <= 1'b0;
      armed_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      out_reg        <= '0;
      count_reg      <= '0;
      residual_reg   <= 1'b0;
      unsup_reg      <= 1'b0;
    end else begin
      prev_valid_reg <= eff_valid;
      armed_reg      <= armed_reg | ~data_valid_i;
      if (first_beat) type_reg <= packet_type_i;
      buf_reg      <= buf_next;
      fill_reg     <= fill_next;
      valid_reg    <= emit;
      if (emit) out_reg <= pixels;
      residual_reg <= flush & (fill_shift != 5'd0);
      if (first_beat || (!eff_valid && !prev_valid_reg)) count_reg <= '0;
      else if (emit) count_reg <= count_reg + 16'd4;
      if (first_beat) unsup_reg <= ~supported;
      else if (!eff_valid) unsup_reg <= 1'b0;
    end
  end

  assign output_valid_o = valid_reg;
  assign output_o       = out_reg;
  assign pixel_count_o  = count_reg;
  assign residual_err_o = residual_reg;
  assign unsupported_o  = unsup_reg;

endmodule

// File: tb/tb_mipi_rx_raw_unpacker.sv
// Directed bench: two 4-lane instances (MSB/LSB alignment) share stimulus, a 2-lane instance covers RAW14.
module tb_mipi_rx_raw_unpacker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dv = 1'b0, dv_c = 1'b0;
  logic [31:0] data = '0;
  logic [15:0] data_c = '0;
  logic [2:0]  ptype = 3'd2, ptype_c = 3'd5;

  logic        valid_a, valid_b, valid_c, res_a, res_b, res_c, uns_a, uns_b, uns_c;
  logic [63:0] out_a, out_b, out_c;
  logic [15:0] pc_a, pc_b, pc_c;

  always #5 clk = ~clk;

  mipi_rx_raw_unpacker #(.LANES(4), .ALIGN_LSB(1'b0)) dut_a (
    .clk_i(clk), .reset_i(reset), .data_valid_i(dv), .data_i(data), .packet_type_i(ptype),
    .output_valid_o(valid_a), .output_o(out_a), .pixel_count_o(pc_a),
    .residual_err_o(res_a), .unsupported_o(uns_a));

  mipi_rx_raw_unpacker #(.LANES(4), .ALIGN_LSB(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset), .data_valid_i(dv), .data_i(data), .packet_type_i(ptype),
    .output_valid_o(valid_b), .output_o(out_b), .pixel_count_o(pc_b),
    .residual_err_o(res_b), .unsupported_o(uns_b));

  mipi_rx_raw_unpacker #(.LANES(2), .ALIGN_LSB(1'b0)) dut_c (
    .clk_i(clk), .reset_i(reset), .data_valid_i(dv_c), .data_i(data_c), .packet_type_i(ptype_c),
    .output_valid_o(valid_c), .output_o(out_c), .pixel_count_o(pc_c),
    .residual_err_o(res_c), .unsupported_o(uns_c));

  int checks = 0, errors = 0;
  int ticks, emits_a, emits_b, emits_c, first_tick_a, last_tick_a, first_tick_c;
  int res_a_n, res_c_n, res_tick_c, uns_n;
  logic [63:0] last_a, last_b, last_c;

  typedef struct {
    logic [2:0]  t0;
    logic [2:0]  t1;
    logic [63:0] bytes;
    int          emits;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    int          res;
    int          etick;
    logic        uns;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic clear_mon();
    ticks = 0; emits_a = 0; emits_b = 0; emits_c = 0;
    first_tick_a = 0; last_tick_a = 0; first_tick_c = 0;
    res_a_n = 0; res_c_n = 0; res_tick_c = 0; uns_n = 0;
    last_a = '0; last_b = '0; last_c = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
    if (valid_a) begin
      emits_a++; last_a = out_a; last_tick_a = ticks;
      if (first_tick_a == 0) first_tick_a = ticks;
    end
    if (valid_b) begin emits_b++; last_b = out_b; end
    if (valid_c) begin
      emits_c++; last_c = out_c;
      if (first_tick_c == 0) first_tick_c = ticks;
    end
    if (res_a) res_a_n++;
    if (res_c) begin res_c_n++; res_tick_c = ticks; end
    if (uns_a) uns_n++;
  endtask

  task automatic run_vec(input int i);
    clear_mon();
    dv = 1'b1; ptype = vecs[i].t0; data = vecs[i].bytes[31:0];
    tick();
    chk($sformatf("v%0d unsupported", i), 64'(uns_a), 64'(vecs[i].uns));
    ptype = vecs[i].t1; data = vecs[i].bytes[63:32];
    tick();
    dv = 1'b0; data = '0;
    tick();
    chk($sformatf("v%0d pixel_count", i), 64'(pc_a), 64'(4 * vecs[i].emits));
    tick();
    chk($sformatf("v%0d count_clear", i), 64'(pc_a), 64'd0);
    chk($sformatf("v%0d emits", i), 64'(emits_a), 64'(vecs[i].emits));
    chk($sformatf("v%0d out_msb", i), last_a, vecs[i].exp_a);
    chk($sformatf("v%0d out_lsb", i), last_b, vecs[i].exp_b);
    chk($sformatf("v%0d residual", i), 64'(res_a_n), 64'(vecs[i].res));
    chk($sformatf("v%0d emit_tick", i), 64'(last_tick_a), 64'(vecs[i].etick));
  endtask

  initial begin
    vecs[0] = '{3'd3, 3'd3, 64'h0000_00E4_4433_2211, 1,
                64'h1100_2240_3380_44C0, 64'h0044_0089_00CE_0113, 1, 3, 1'b0};
    vecs[1] = '{3'd4, 3'd4, 64'h0000_21CD_AB21_CDAB, 1,
                64'hAB10_CD20_AB10_CD20, 64'h0AB1_0CD2_0AB1_0CD2, 1, 3, 1'b0};
    vecs[2] = '{3'd2, 3'd2, 64'h0807_0605_0403_0201, 2,
                64'h0500_0600_0700_0800, 64'h0005_0006_0007_0008, 0, 3, 1'b0};
    vecs[3] = '{3'd5, 3'd5, 64'h00DE_BC9A_7856_3412, 1,
                64'h1268_34C8_56AC_78DC, 64'h049A_0D32_15AB_1E37, 1, 3, 1'b0};
    vecs[4] = '{3'd2, 3'd5, 64'hA8A7_A6A5_A4A3_A2A1, 2,
                64'hA500_A600_A700_A800, 64'h00A5_00A6_00A7_00A8, 0, 3, 1'b0};
    vecs[5] = '{3'd0, 3'd3, 64'h1122_3344_5566_7788, 0,
                64'h0, 64'h0, 0, 0, 1'b1};

    clear_mon();
    tick(); tick();
    chk("reset valid", 64'(valid_a), 64'd0);
    chk("reset output", out_a, 64'd0);
    chk("reset count", 64'(pc_a), 64'd0);
    chk("reset flags", {61'd0, res_a, uns_a, valid_c}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // RAW8 stream of 10 beats: emissions must follow each stored beat by one cycle.
    clear_mon();
    ptype = 3'd2;
    for (int k = 0; k < 10; k++) begin
      dv = 1'b1; data = 32'h0403_0201 + 32'(k) * 32'h0404_0404;
      tick();
    end
    dv = 1'b0;
    tick();
    chk("raw8 stream emits", 64'(emits_a), 64'd10);
    chk("raw8 stream first", 64'(first_tick_a), 64'd2);
    chk("raw8 stream last", 64'(last_tick_a), 64'd11);
    chk("raw8 stream count", 64'(pc_a), 64'd40);
    chk("raw8 stream data", last_a, 64'h2500_2600_2700_2800);
    tick();

    // Long RAW8 packet: pixel count wraps modulo 2^16.
    clear_mon();
    for (int k = 0; k < 16385; k++) begin
      dv = 1'b1; data = 32'(k);
      tick();
    end
    dv = 1'b0;
    tick();
    chk("wrap emits", 64'(emits_a), 64'd16385);
    chk("wrap count", 64'(pc_a), 64'd4);
    tick();

    // Two-lane RAW14 packet: one emission and a residual pulse at flush.
    clear_mon();
    ptype_c = 3'd5;
    for (int k = 0; k < 5; k++) begin
      dv_c = 1'b1;
      case (k)
        0: data_c = 16'h3412;
        1: data_c = 16'h7856;
        2: data_c = 16'hBC9A;
        3: data_c = 16'h00DE;
        default: data_c = 16'h0000;
      endcase
      tick();
    end
    dv_c = 1'b0;
    tick(); tick();
    chk("raw14 emits", 64'(emits_c), 64'd1);
    chk("raw14 emit tick", 64'(first_tick_c), 64'd5);
    chk("raw14 data", last_c, 64'h1268_34C8_56AC_78DC);
    chk("raw14 residual count", 64'(res_c_n), 64'd1);
    chk("raw14 residual tick", 64'(res_tick_c), 64'd6);

    // Unsupported type held for 8 beats.
    clear_mon();
    ptype = 3'd0;
    for (int k = 0; k < 8; k++) begin
      dv = 1'b1; data = 32'hDEAD_0000 + 32'(k);
      tick();
    end
    dv = 1'b0;
    tick();
    chk("unsup high cycles", 64'(uns_n), 64'd8);
    chk("unsup no emission", 64'(emits_a), 64'd0);
    chk("unsup cleared", 64'(uns_a), 64'd0);
    tick();

    // Reset in the middle of a RAW10 packet.
    clear_mon();
    ptype = 3'd3;
    for (int k = 0; k < 4; k++) begin
      dv = 1'b1; data = 32'h4433_2211;
      tick();
    end
    chk("pre-reset emits", 64'(emits_a), 64'd2);
    reset = 1'b1;
    tick();
    chk("mid reset outputs", {out_a, 16'h0}, 80'd0);
    chk("mid reset status", {44'd0, pc_a, 1'b0, valid_a, res_a, uns_a}, 64'd0);
    reset = 1'b0;
    clear_mon();
    for (int k = 0; k < 3; k++) tick();
    chk("post reset ignored", 64'(emits_a), 64'd0);
    dv = 1'b0;
    tick();
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
